latch_write_sequencer: RTL and testbench
========================================

Name: latch_write_sequencer

Overview:
- Upstream driver for the board's level-sensitive D latch.
- Turns a raw pushbutton (BTN) and data switch (DIN) into a clean, glitch-free write: D set up, EN pulsed high, D held.
- Outputs D/EN connect directly to the latch's D and EN inputs. Both are fully registered so the latch gate never sees a combinational glitch.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised button must differ from the debounced level before that level flips (>=1)
- SETUP_CYCLES, 2, cycles D is stable with EN low before EN rises (>=1)
- PULSE_CYCLES, 3, cycles EN is held high (>=1)
- HOLD_CYCLES, 2, cycles D is held with EN low after EN falls (>=1)
- CW, 8, timing counter width; every cycle parameter must be < 2**CW

Ports:
- CLK  in  1  system clock, rising edge
- R    in  1  asynchronous, active-low reset
- BTN  in  1  raw asynchronous pushbutton, active-high, bouncy
- DIN  in  1  raw asynchronous data switch
- D    out 1  data to latch, registered
- EN   out 1  latch enable, registered
- BUSY out 1  high from write acceptance until return to IDLE
- DONE out 1  one-cycle pulse when a write sequence completes

Behaviour:
- Reset (R low, asynchronous, any state): D=0, EN=0, BUSY=0, DONE=0, state=IDLE, sync flops=0, debounced level=0, counters=0. Reset mid-write aborts it: EN falls immediately, with no completion and no DONE. After R rises, the first activity is possible on the next CLK edge.
- Synchronisers: two flops each on BTN and DIN, giving btn_s and din_s.
- Debounce:
  - When btn_s != deb, the counter increments; when btn_s == deb, the counter clears.
  - On the edge where the count would reach DEBOUNCE_CYCLES, deb toggles and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES never toggles deb.
- Press event: the edge at which deb goes 0->1. It is accepted only in IDLE. Presses during BUSY are dropped, not queued. A new press requires deb to return to 0 first.
- FSM states: IDLE, SETUP, ENABLE, HOLD.
- IDLE: EN=0, BUSY=0. On a press event, D<=din_s, BUSY<=1, timer cleared, go to SETUP.
- SETUP: EN=0. After SETUP_CYCLES cycles, EN<=1 and go to ENABLE.
- ENABLE: EN=1. After PULSE_CYCLES cycles, EN<=0 and go to HOLD.
- HOLD: EN=0. After HOLD_CYCLES cycles, go to IDLE, BUSY<=0, DONE<=1 for exactly one cycle.
- D: changes only on press acceptance and retains its value indefinitely afterwards. DIN changes while BUSY never affect D.
- Timing: EN is never high in the same cycle D changes. D is constant for SETUP_CYCLES before and HOLD_CYCLES after every EN high window.
- Latency with defaults, BTN and DIN high and stable before edge 1:
  - btn_s=1 after edge 2; deb=1, state SETUP, BUSY=1, D=1 after edge 6.
  - EN=1 after edge 8; EN=0 after edge 11.
  - State IDLE, BUSY=0, DONE=1 after edge 13; DONE=0 after edge 14.
- Simultaneous events: a press event on the same edge that HOLD completes is dropped, because the state is not yet IDLE.

Decomposition:
- Package latch_seq_pkg:
  - state typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD}
  - default timing constants
- Sub-module btn_debounce (CLK, R, raw in -> level out, parameter DEBOUNCE_CYCLES, includes the 2-flop synchroniser). The top-level module holds the DIN synchroniser, FSM and timer.

Test Plan:
- Reset: R=0 while BUSY in ENABLE -> EN=0, D=0, BUSY=0, DONE=0 asynchronously (before the next edge). Release R with BTN low -> outputs stay 0.
- Write 1: DIN=1, BTN high for 20 cycles -> D=1 after edge 6, EN high exactly edges 8-11, DONE single pulse after edge 13, D stays 1 with EN=0 afterwards.
- Write 0 after 1: DIN=0, second clean press -> D falls to 0 while EN=0, with 2 cycles of setup. EN pulses for 3 cycles. The latch-side model shows Q=0 after EN falls.
- Bounce rejection: BTN toggles high 3 cycles / low 1 cycle repeatedly -> deb never rises, BUSY stays 0, EN stays 0.
- Busy lockout and data hold: during SETUP, release then re-press BTN and flip DIN -> no second sequence, D unchanged, exactly one DONE.
- Boundary: all cycle parameters=1 -> EN high exactly one cycle, D stable one cycle each side, DONE 3 cycles after acceptance.

Source files
------------

// File: rtl/latch_seq_pkg.sv
// rtl/latch_seq_pkg.sv - shared state encoding and default timing for the latch write sequencer
package latch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_SETUP_CYCLES    = 2;
    localparam int DEF_PULSE_CYCLES    = 3;
    localparam int DEF_HOLD_CYCLES     = 2;
    localparam int DEF_CW              = 8;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus run-length debounce for the pushbutton
module btn_debounce
    import latch_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CW              = DEF_CW
) (
    input  logic CLK,
    input  logic R,
    input  logic i_raw,
    output logic o_level,
    output logic o_level_nxt
);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_flip;

    assign w_diff = (r_sync2 != r_deb);
    // The level flips on the edge where the disagreement run would reach DEBOUNCE_CYCLES.
    assign w_flip = w_diff && (r_cnt == DEB_LAST);

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (w_flip) begin
                r_deb <= ~r_deb;
                r_cnt <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level     = r_deb;
    assign o_level_nxt = w_flip ? ~r_deb : r_deb;

endmodule

// File: rtl/latch_write_sequencer.sv
// rtl/latch_write_sequencer.sv - glitch-free D/EN write sequencing for a level-sensitive D latch
module latch_write_sequencer
    import latch_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int CW              = DEF_CW
) (
    input  logic CLK,
    input  logic R,
    input  logic BTN,
    input  logic DIN,
    output logic D,
    output logic EN,
    output logic BUSY,
    output logic DONE
);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);

    logic          w_level;
    logic          w_level_nxt;
    logic          w_press;
    logic          r_din_s1;
    logic          r_din_s2;
    state_t        r_state;
    logic [CW-1:0] r_timer;
    logic          r_d;
    logic          r_en;
    logic          r_busy;
    logic          r_done;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CW             (CW)
    ) u_btn_debounce (
        .CLK        (CLK),
        .R          (R),
        .i_raw      (BTN),
        .o_level    (w_level),
        .o_level_nxt(w_level_nxt)
    );

    // Press is taken on the same edge the debounced level rises, not one cycle later.
    assign w_press = w_level_nxt && !w_level;

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_din_s1 <= 1'b0;
            r_din_s2 <= 1'b0;
        end else begin
            r_din_s1 <= DIN;
            r_din_s2 <= r_din_s1;
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_d     <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_press) begin
                        r_d     <= r_din_s2;
                        r_busy  <= 1'b1;
                        r_timer <= '0;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_timer == SETUP_LAST) begin
                        r_timer <= '0;
                        r_en    <= 1'b1;
                        r_state <= ENABLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ENABLE: begin
                    if (r_timer == PULSE_LAST) begin
                        r_timer <= '0;
                        r_en    <= 1'b0;
                        r_state <= HOLD;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                HOLD: begin
                    if (r_timer == HOLD_LAST) begin
                        r_timer <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_timer <= '0;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign D    = r_d;
    assign EN   = r_en;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// tb/tb_latch_write_sequencer.sv - randomized bench against a schedule-based model, default and minimum timing
module tb_latch_write_sequencer;

    logic CLK = 1'b0;
    logic R   = 1'b0;
    logic BTN = 1'b0;
    logic DIN = 1'b0;
    logic D0, EN0, BUSY0, DONE0;
    logic D1, EN1, BUSY1, DONE1;
    logic q = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    latch_write_sequencer u_dut (
        .CLK(CLK), .R(R), .BTN(BTN), .DIN(DIN),
        .D(D0), .EN(EN0), .BUSY(BUSY0), .DONE(DONE0)
    );

    latch_write_sequencer #(
        .DEBOUNCE_CYCLES(1), .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1), .CW(8)
    ) u_dut_min (
        .CLK(CLK), .R(R), .BTN(BTN), .DIN(DIN),
        .D(D1), .EN(EN1), .BUSY(BUSY1), .DONE(DONE1)
    );

    // Model: a write accepted at edge A drives EN for edges A+S..A+S+P-1 and ends at A+S+P+H.
    typedef struct {
        logic b1, b2, d1, d2, deb;
        int   run;
        logic busy;
        int   n, start;
        logic d, en, done;
    } mdl_t;

    mdl_t m0 = '{default: 0};
    mdl_t m1 = '{default: 0};

    function automatic mdl_t mdl_reset();
        mdl_t r = '{default: 0};
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic btn, logic din, int db, int s, int p, int h);
        mdl_t r;
        logic press;
        int   el;
        r      = m;
        r.n    = m.n + 1;
        r.b1   = btn;
        r.b2   = m.b1;
        r.d1   = din;
        r.d2   = m.d1;
        r.done = 1'b0;
        press  = 1'b0;
        if (m.b2 != m.deb) begin
            if (m.run + 1 == db) begin
                r.deb = !m.deb;
                r.run = 0;
                press = !m.deb;
            end else begin
                r.run = m.run + 1;
            end
        end else begin
            r.run = 0;
        end
        if (m.busy) begin
            el   = r.n - m.start;
            r.en = (el >= s) && (el < s + p);
            if (el == s + p + h) begin
                r.busy = 1'b0;
                r.done = 1'b1;
            end
        end else if (press) begin
            r.busy  = 1'b1;
            r.start = r.n;
            r.d     = m.d2;
        end
        return r;
    endfunction

    always @(posedge CLK or negedge R) begin
        if (!R) begin
            m0 <= mdl_reset();
            m1 <= mdl_reset();
        end else begin
            m0 <= mdl_step(m0, BTN, DIN, 4, 2, 3, 2);
            m1 <= mdl_step(m1, BTN, DIN, 1, 1, 1, 1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic b, input logic d);
        BTN = b;
        DIN = d;
        @(posedge CLK);
        #2;
        if (EN0) q = D0;
        check("d0", D0, m0.d);
        check("en0", EN0, m0.en);
        check("busy0", BUSY0, m0.busy);
        check("done0", DONE0, m0.done);
        check("d1", D1, m1.d);
        check("en1", EN1, m1.en);
        check("busy1", BUSY1, m1.busy);
        check("done1", DONE1, m1.done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    int dones;
    logic b;
    int seg;

    initial begin
        repeat (2) @(posedge CLK);
        #2;
        check("rst_d", D0, 0);
        check("rst_en", EN0, 0);
        check("rst_busy", BUSY0, 0);
        check("rst_done", DONE0, 0);
        R = 1'b1;

        // Write 1 with latency pinned edge by edge.
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 1'b1);
            if (i == 5)  check("w1_busy_e5", BUSY0, 0);
            if (i == 6)  begin check("w1_busy_e6", BUSY0, 1); check("w1_d_e6", D0, 1); end
            if (i == 7)  check("w1_en_e7", EN0, 0);
            if (i == 8)  check("w1_en_e8", EN0, 1);
            if (i == 10) check("w1_en_e10", EN0, 1);
            if (i == 11) check("w1_en_e11", EN0, 0);
            if (i == 12) check("w1_done_e12", DONE0, 0);
            if (i == 13) begin check("w1_done_e13", DONE0, 1); check("w1_busy_e13", BUSY0, 0); end
            if (i == 14) check("w1_done_e14", DONE0, 0);
            if (i == 3)  check("min_busy_e3", BUSY1, 1);
            if (i == 4)  check("min_en_e4", EN1, 1);
            if (i == 5)  check("min_en_e5", EN1, 0);
            if (i == 6)  check("min_done_e6", DONE1, 1);
            if (i == 7)  check("min_done_e7", DONE1, 0);
        end
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1);
        check("w1_d_after", D0, 1);
        check("w1_latch_q", q, 1);

        // Write 0 after 1.
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
        idle(12);
        check("w0_d_after", D0, 0);
        check("w0_latch_q", q, 0);

        // Reset while EN is high.
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1);
        check("mid_en_high", EN0, 1);
        R = 1'b0;
        #1;
        check("async_d", D0, 0);
        check("async_en", EN0, 0);
        check("async_busy", BUSY0, 0);
        check("async_done", DONE0, 0);
        BTN = 1'b0;
        DIN = 1'b0;
        @(posedge CLK);
        #2;
        R = 1'b1;
        idle(10);

        // Bounce: 3 high / 1 low never satisfies a 4-cycle debounce.
        for (int i = 0; i < 40; i++) begin
            cyc((i % 4) != 3, 1'($urandom));
            check("bounce_busy", BUSY0, 0);
            check("bounce_en", EN0, 0);
        end
        idle(12);

        // Busy lockout: glitch and re-press during the write, flipping DIN.
        dones = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 7) cyc(1'b0, 1'b0);
            else if (i <= 6) cyc(1'b1, 1'b1);
            else cyc(1'b1, 1'(i));
            if (DONE0) dones++;
            if (i >= 6) check("lock_d", D0, 1);
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'($urandom));
            if (DONE0) dones++;
        end
        check("lock_dones", dones, 1);
        check("lock_d_end", D0, 1);

        // Random button segments and data.
        for (int k = 0; k < 80; k++) begin
            b   = 1'($urandom);
            seg = $urandom_range(1, 8);
            for (int i = 0; i < seg; i++) cyc(b, 1'($urandom));
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
